// File: rtl/types_pkg.sv
// Shared types and constants for the writeback stage and its register file.
package types_pkg;

    localparam int unsigned RD_MSB = 11;
    localparam int unsigned RD_LSB = 8;

    localparam logic [3:0] R0_ADDR = 4'd0;

    typedef struct packed {
        logic        valid;
        logic [3:0]  rd;
        logic [31:0] data;
        logic        reg_wr;
        logic        r0_en;
    } mem_wb_t;

endpackage

// File: rtl/reg_file.sv
// Architectural register file: two write ports (R0 upper-half port has priority)
// and two combinational read ports with write-through bypass.
module reg_file
    import types_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [AW-1:0]     wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              r0_wr_en,
    input  logic [DATA_W-1:0] r0_wr_data,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b
);

    logic [DATA_W-1:0] r_regs [NREGS];

    // R0 upper write is issued last so it overrides a same-edge low-half write to R0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < NREGS; i++) begin
                r_regs[i] <= '0;
            end
        end else begin
            if (wr_en) begin
                r_regs[wr_addr] <= wr_data;
            end
            if (r0_wr_en) begin
                r_regs[AW'(R0_ADDR)] <= r0_wr_data;
            end
        end
    end

    always_comb begin
        rd_data_a = r_regs[rd_addr_a];
        if (r0_wr_en && (rd_addr_a == AW'(R0_ADDR))) begin
            rd_data_a = r0_wr_data;
        end else if (wr_en && (rd_addr_a == wr_addr)) begin
            rd_data_a = wr_data;
        end
    end

    always_comb begin
        rd_data_b = r_regs[rd_addr_b];
        if (r0_wr_en && (rd_addr_b == AW'(R0_ADDR))) begin
            rd_data_b = r0_wr_data;
        end else if (wr_en && (rd_addr_b == wr_addr)) begin
            rd_data_b = wr_data;
        end
    end

endmodule

// File: rtl/stage_four.sv
// Writeback stage: MEM/WB pipeline register, halt-gated commit to the register
// file, forwarding outputs and retired-instruction counter.
module stage_four
    import types_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned NREGS  = 16,
    parameter int unsigned AW     = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              halt_sys,
    input  logic              in_valid,
    input  logic [15:0]       instruction,
    input  logic [31:0]       data,
    input  logic              reg_wr,
    input  logic              r0_en,
    input  logic [AW-1:0]     rd_addr_a,
    input  logic [AW-1:0]     rd_addr_b,
    output logic [DATA_W-1:0] rd_data_a,
    output logic [DATA_W-1:0] rd_data_b,
    output logic              wb_en,
    output logic [AW-1:0]     wb_addr,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_r0_en,
    output logic [DATA_W-1:0] wb_r0_data,
    output logic [15:0]       retired
);

    mem_wb_t     r_mw;
    logic [15:0] r_retired;
    logic        w_commit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mw <= '0;
        end else if (!halt_sys) begin
            r_mw <= '{valid:  in_valid,
                      rd:     instruction[RD_MSB:RD_LSB],
                      data:   data,
                      reg_wr: reg_wr,
                      r0_en:  r0_en};
        end
    end

    // A held instruction commits only on the first non-halted edge.
    assign w_commit = r_mw.valid & ~halt_sys;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_retired <= '0;
        end else if (w_commit) begin
            r_retired <= r_retired + 16'd1;
        end
    end

    assign wb_en      = w_commit & r_mw.reg_wr;
    assign wb_r0_en   = w_commit & r_mw.r0_en;
    assign wb_addr    = r_mw.rd;
    assign wb_data    = r_mw.data[DATA_W-1:0];
    assign wb_r0_data = r_mw.data[31:16];
    assign retired    = r_retired;

    reg_file #(
        .DATA_W (DATA_W),
        .NREGS  (NREGS),
        .AW     (AW)
    ) u_reg_file (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wb_en),
        .wr_addr    (wb_addr),
        .wr_data    (wb_data),
        .r0_wr_en   (wb_r0_en),
        .r0_wr_data (wb_r0_data),
        .rd_addr_a  (rd_addr_a),
        .rd_addr_b  (rd_addr_b),
        .rd_data_a  (rd_data_a),
        .rd_data_b  (rd_data_b)
    );

endmodule

// File: tb/tb_stage_four.sv
// Self-checking bench for stage_four: behavioural model compared every cycle
// plus hand-computed literal checks on directed vectors.
`timescale 1ns/1ps
module tb_stage_four;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt_sys;
    logic        in_valid;
    logic [15:0] instruction;
    logic [31:0] data;
    logic        reg_wr;
    logic        r0_en;
    logic [3:0]  rd_addr_a;
    logic [3:0]  rd_addr_b;
    logic [15:0] rd_data_a;
    logic [15:0] rd_data_b;
    logic        wb_en;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic        wb_r0_en;
    logic [15:0] wb_r0_data;
    logic [15:0] retired;

    int unsigned total = 0;
    int unsigned bad   = 0;

    stage_four #(.DATA_W(16), .NREGS(16), .AW(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .halt_sys    (halt_sys),
        .in_valid    (in_valid),
        .instruction (instruction),
        .data        (data),
        .reg_wr      (reg_wr),
        .r0_en       (r0_en),
        .rd_addr_a   (rd_addr_a),
        .rd_addr_b   (rd_addr_b),
        .rd_data_a   (rd_data_a),
        .rd_data_b   (rd_data_b),
        .wb_en       (wb_en),
        .wb_addr     (wb_addr),
        .wb_data     (wb_data),
        .wb_r0_en    (wb_r0_en),
        .wb_r0_data  (wb_r0_data),
        .retired     (retired)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: architectural registers, the one instruction in flight, and the retire count.
    logic [15:0] m_regs [16];
    logic        p_valid, p_wr, p_r0;
    logic [3:0]  p_rd;
    logic [31:0] p_data;
    logic [15:0] m_ret;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) m_regs[i] = 16'h0;
            p_valid = 0; p_wr = 0; p_r0 = 0; p_rd = 0; p_data = 0; m_ret = 0;
        end else if (!halt_sys) begin
            if (p_valid) begin
                if (p_wr) m_regs[p_rd] = p_data[15:0];
                if (p_r0) m_regs[0] = p_data[31:16];
                m_ret = m_ret + 16'd1;
            end
            p_valid = in_valid;
            p_rd    = instruction[11:8];
            p_data  = data;
            p_wr    = reg_wr;
            p_r0    = r0_en;
        end
    end

    function automatic logic [15:0] model_read(input logic [3:0] a);
        logic e_en, e_r0;
        e_en = p_valid & p_wr & ~halt_sys;
        e_r0 = p_valid & p_r0 & ~halt_sys;
        if (e_r0 && a == 4'd0) return p_data[31:16];
        if (e_en && a == p_rd) return p_data[15:0];
        return m_regs[a];
    endfunction

    always @(negedge clk) begin
        if (!rst) begin
            check("wb_en",      {31'b0, wb_en},    {31'b0, p_valid & p_wr & ~halt_sys});
            check("wb_r0_en",   {31'b0, wb_r0_en}, {31'b0, p_valid & p_r0 & ~halt_sys});
            check("wb_addr",    {28'b0, wb_addr},  {28'b0, p_rd});
            check("wb_data",    {16'b0, wb_data},  {16'b0, p_data[15:0]});
            check("wb_r0_data", {16'b0, wb_r0_data}, {16'b0, p_data[31:16]});
            check("retired",    {16'b0, retired},  {16'b0, m_ret});
            check("rd_data_a",  {16'b0, rd_data_a}, {16'b0, model_read(rd_addr_a)});
            check("rd_data_b",  {16'b0, rd_data_b}, {16'b0, model_read(rd_addr_b)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] ins, input logic [31:0] d,
                         input logic rw, input logic r0);
        in_valid = v; instruction = ins; data = d; reg_wr = rw; r0_en = r0;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < 16; i++) begin
            rd_addr_a = 4'(i);
            #1;
            check(name, {16'b0, rd_data_a}, 32'h0);
        end
    endtask

    logic [15:0] ret_save;
    logic [15:0] vec_ins  [6];
    logic [31:0] vec_dat  [6];
    logic [1:0]  vec_ctl  [6];

    initial begin
        vec_ins[0] = 16'h0100; vec_dat[0] = 32'h0000_1111; vec_ctl[0] = 2'b10;
        vec_ins[1] = 16'h0200; vec_dat[1] = 32'h0000_2222; vec_ctl[1] = 2'b10;
        vec_ins[2] = 16'h0100; vec_dat[2] = 32'h0000_3333; vec_ctl[2] = 2'b10;
        vec_ins[3] = 16'h0F00; vec_dat[3] = 32'hAAAA_FFFF; vec_ctl[3] = 2'b11;
        vec_ins[4] = 16'h0200; vec_dat[4] = 32'h5555_4444; vec_ctl[4] = 2'b01;
        vec_ins[5] = 16'h0E00; vec_dat[5] = 32'h0000_6666; vec_ctl[5] = 2'b00;

        rst = 1; halt_sys = 0; rd_addr_a = 0; rd_addr_b = 0;
        drive(0, 16'h0, 32'h0, 0, 0);
        #2;
        check("reset_retired", {16'b0, retired}, 32'h0);
        check("reset_wb_en", {31'b0, wb_en}, 32'h0);
        sweep_zero("reset_read");
        step();
        rst = 0;

        // Basic write to R3 with bypass in the intermediate cycle.
        drive(1, 16'h1300, 32'h0000_ABCD, 1, 0);
        rd_addr_a = 3;
        step();
        drive(0, 16'h0, 32'h0, 0, 0);
        #1 check("basic_bypass", {16'b0, rd_data_a}, 32'h0000_ABCD);
        step();
        check("basic_stored", {16'b0, rd_data_a}, 32'h0000_ABCD);

        // Multiply-style dual write.
        drive(1, 16'h0500, 32'h1234_5678, 1, 1);
        step();
        drive(0, 16'h0, 32'h0, 0, 0);
        step();
        rd_addr_a = 5; rd_addr_b = 0;
        #1;
        check("mult_R5", {16'b0, rd_data_a}, 32'h0000_5678);
        check("mult_R0", {16'b0, rd_data_b}, 32'h0000_1234);

        // Conflict on R0: upper half wins.
        drive(1, 16'h0000, 32'hBEEF_CAFE, 1, 1);
        rd_addr_a = 0;
        step();
        drive(0, 16'h0, 32'h0, 0, 0);
        #1 check("conflict_bypass", {16'b0, rd_data_a}, 32'h0000_BEEF);
        step();
        check("conflict_stored", {16'b0, rd_data_a}, 32'h0000_BEEF);

        // Halt with a pending write to R7.
        drive(1, 16'h0700, 32'h0000_7777, 1, 0);
        rd_addr_a = 7;
        step();
        halt_sys = 1;
        drive(0, 16'h0700, 32'h0000_1111, 1, 1);
        ret_save = retired;
        repeat (3) step();
        check("halt_no_write", {16'b0, rd_data_a}, 32'h0);
        check("halt_retired", {16'b0, retired}, {16'b0, ret_save});
        halt_sys = 0;
        #1 check("release_wb_en", {31'b0, wb_en}, 32'h1);
        step();
        check("release_retired", {16'b0, retired}, {16'b0, ret_save + 16'd1});
        check("release_R7", {16'b0, rd_data_a}, 32'h0000_7777);
        step();
        rd_addr_b = 0;
        #1;
        check("bubble_R7", {16'b0, rd_data_a}, 32'h0000_7777);
        check("bubble_R0", {16'b0, rd_data_b}, 32'h0000_BEEF);
        check("bubble_retired", {16'b0, retired}, {16'b0, ret_save + 16'd1});

        // Back-to-back directed vectors.
        for (int i = 0; i < 6; i++) begin
            drive(1, vec_ins[i], vec_dat[i], vec_ctl[i][1], vec_ctl[i][0]);
            rd_addr_a = vec_ins[i][11:8];
            rd_addr_b = 4'(i);
            step();
        end
        drive(0, 16'h0, 32'h0, 0, 0);
        step();
        step();
        rd_addr_a = 1; rd_addr_b = 2;
        #1;
        check("vec_R1", {16'b0, rd_data_a}, 32'h0000_3333);
        check("vec_R2", {16'b0, rd_data_b}, 32'h0000_2222);
        rd_addr_a = 15; rd_addr_b = 0;
        #1;
        check("vec_R15", {16'b0, rd_data_a}, 32'h0000_FFFF);
        check("vec_R0", {16'b0, rd_data_b}, 32'h0000_5555);

        // Asynchronous reset mid-cycle with a pending write to R9.
        drive(1, 16'h0900, 32'h0000_9999, 1, 1);
        step();
        #3 rst = 1;
        #1;
        check("midrst_wb_en", {31'b0, wb_en}, 32'h0);
        check("midrst_retired", {16'b0, retired}, 32'h0);
        sweep_zero("midrst_read");
        drive(0, 16'h0, 32'h0, 0, 0);
        step();
        rst = 0;

        // Retire counter wrap.
        drive(1, 16'h0000, 32'h0, 0, 0);
        repeat (65536) step();
        check("wrap_ffff", {16'b0, retired}, 32'h0000_FFFF);
        drive(0, 16'h0, 32'h0, 0, 0);
        step();
        check("wrap_zero", {16'b0, retired}, 32'h0);
        step();
        check("wrap_hold", {16'b0, retired}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
